// File: rtl/nms_feeder_if.sv
// Purpose: bundles the pixel-in, NMS-controller and result-out signals of nms_feeder.
// Latency: none; wires only.
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface nms_feeder_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_sol;
  logic [1:0]   in_angle;
  logic [7:0]   in_mag;
  logic         anchor_moving;
  logic [27:0]  gradient_angle;
  logic [111:0] gradient_mag;
  logic [95:0]  nms_out;
  logic         nms_final;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic         err_timeout;

  // Environment side: feeds pixels, plays the NMS controller, consumes results.
  modport master (
    output in_valid, in_sol, in_angle, in_mag, nms_out, nms_final, out_ready,
    input  in_ready, anchor_moving, gradient_angle, gradient_mag, out_valid, out_data, err_timeout
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_sol, in_angle, in_mag, nms_out, nms_final, out_ready,
    output in_ready, anchor_moving, gradient_angle, gradient_mag, out_valid, out_data, err_timeout
  );
endinterface

// File: rtl/nms_feeder.sv
// Purpose: stages gradient pixels into a 14-wide window, kicks the NMS controller, captures its result.
// Latency: window issued the cycle after the staging target fills; result visible the cycle after nms_final.
// Backpressure: in_ready drops once the staging target is met; no new window while out_valid is unconsumed.
module nms_feeder #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  nms_feeder_if.slave  bus
);

  localparam int WCW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // Pixel packed as {angle, mag}; element 13 is the newest.
  logic [13:0][9:0] staging;
  logic [13:0][9:0] win_q;
  logic [3:0]       cnt;
  logic [3:0]       need;
  logic [WCW-1:0]   wait_cnt;
  state_t           state;
  logic             anchor_q;
  logic             out_valid_q;
  logic [95:0]      out_data_q;
  logic             err_q;
  logic             accept;

  assign bus.in_ready      = (cnt != need);
  assign accept            = bus.in_valid && bus.in_ready;
  assign bus.anchor_moving = anchor_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.err_timeout   = err_q;

  // Spread the held window onto the flat angle/magnitude buses.
  always_comb begin
    bus.gradient_angle = '0;
    bus.gradient_mag   = '0;
    for (int j = 0; j < 14; j++) begin
      bus.gradient_angle[2*j +: 2] = win_q[j][9:8];
      bus.gradient_mag[8*j +: 8]   = win_q[j][7:0];
    end
  end

  // Staging shift register: accepted pixel enters the top, oldest falls off the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
    end else if (accept) begin
      staging <= {{bus.in_angle, bus.in_mag}, staging[13:1]};
    end
  end

  // Control FSM with fill counters, window hold, result capture and timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      anchor_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      win_q       <= '0;
      cnt         <= 4'd0;
      need        <= 4'd14;
      wait_cnt    <= '0;
      err_q       <= 1'b0;
    end else begin
      anchor_q <= 1'b0;

      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A row start restarts the fill; earlier partial pixels stay in staging but no longer count.
      if (accept) begin
        if (bus.in_sol) begin
          cnt  <= 4'd1;
          need <= 4'd14;
        end else begin
          cnt  <= 4'(cnt + 4'd1);
        end
      end

      case (state)
        S_IDLE: begin
          // cnt==need implies in_ready is low, so no accept competes with this reload.
          if ((cnt == need) && !out_valid_q) begin
            state    <= S_ISSUE;
            anchor_q <= 1'b1;
            win_q    <= staging;
            cnt      <= 4'd0;
            need     <= 4'd12;
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still counts as a capture.
          if (bus.nms_final) begin
            out_data_q  <= bus.nms_out;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= WCW'(wait_cnt + 1'b1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nms_feeder.sv
// Purpose: directed-plus-random bench for nms_feeder against a history-based window model.
// Latency: checks anchor/result timing cycle by cycle.
// Backpressure: randomised in_valid gaps; out_ready held off to exercise result stalls.
module tb_nms_feeder;

  logic tb_clk = 1'b0;
  logic rst    = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  nms_feeder_if bus ();

  nms_feeder #(.TIMEOUT(64)) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 tb_clk = ~tb_clk;

  // Reference model: every accepted pixel ever seen (last 14 form the window),
  // plus pixels counted since the last window or row start and the target count.
  logic [9:0] hist[$];
  int         acc_since;
  int         need_m;
  int         anchor_cnt;
  bit         anchor_pending;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    hist.delete();
    for (int i = 0; i < 14; i++) hist.push_back(10'd0);
    acc_since      = 0;
    need_m         = 14;
    anchor_pending = 1'b0;
  endtask

  task automatic check_window();
    logic [111:0] em;
    logic [27:0]  ea;
    int           base;
    base = hist.size() - 14;
    em   = '0;
    ea   = '0;
    for (int j = 0; j < 14; j++) begin
      em[8*j +: 8] = hist[base + j][7:0];
      ea[2*j +: 2] = hist[base + j][9:8];
    end
    chk("win_mag", bus.gradient_mag, em);
    chk("win_ang", bus.gradient_angle, ea);
  endtask

  // One clock: advance the model with whatever was accepted on this edge, then check in_ready.
  task automatic tick();
    logic       acc;
    logic       sol;
    logic [9:0] pix;
    acc = bus.in_valid && bus.in_ready;
    sol = bus.in_sol;
    pix = {bus.in_angle, bus.in_mag};
    @(posedge tb_clk);
    #1;
    if (rst) begin
      reset_model();
    end else begin
      if (acc) begin
        hist.push_back(pix);
        if (sol) begin
          acc_since = 1;
          need_m    = 14;
        end else begin
          acc_since++;
        end
      end
      if (bus.anchor_moving) begin
        anchor_cnt++;
        anchor_pending = 1'b1;
        check_window();
        acc_since = 0;
        need_m    = 12;
      end
    end
    chk("in_ready", bus.in_ready, (acc_since != need_m));
  endtask

  task automatic send_pix(input logic sol, input logic [1:0] ang, input logic [7:0] mag);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    bus.in_sol   = sol;
    bus.in_angle = ang;
    bus.in_mag   = mag;
    while (!got && n < 64) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      got = bus.in_valid && bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    chk("pix_accepted", got, 1'b1);
  endtask

  task automatic wait_anchor(input int budget);
    int n;
    n = 0;
    while (!anchor_pending && n < budget) begin
      tick();
      n++;
    end
    chk("anchor_seen", anchor_pending, 1'b1);
    anchor_pending = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_anchor"}, bus.anchor_moving, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_data"}, bus.out_data, 96'd0);
    chk({tag, "_gang"}, bus.gradient_angle, 28'd0);
    chk({tag, "_gmag"}, bus.gradient_mag, 112'd0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_err"}, bus.err_timeout, 1'b0);
  endtask

  initial begin
    logic [95:0] d2;
    logic [95:0] all_ff;
    int          a0;

    all_ff         = {12{8'hFF}};
    anchor_cnt     = 0;
    bus.in_valid   = 1'b0;
    bus.in_sol     = 1'b0;
    bus.in_angle   = 2'd0;
    bus.in_mag     = 8'd0;
    bus.nms_out    = '0;
    bus.nms_final  = 1'b0;
    bus.out_ready  = 1'b0;
    reset_model();

    // Reset state, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;

    // Row start, 14 pixels mag=j angle=2 -> one window with element j = j.
    for (int j = 0; j < 14; j++) send_pix(j == 0, 2'd2, 8'(j));
    chk("full_in_ready", bus.in_ready, 1'b0);
    wait_anchor(4);
    for (int j = 0; j < 14; j++) chk("w1_mag_elem", bus.gradient_mag[8*j +: 8], 8'(j));
    chk("w1_ang_all2", bus.gradient_angle, 28'hAAAAAAA);

    // NMS answers 5 cycles after the pulse with all 0xFF.
    tick();
    chk("pulse_one_cycle", bus.anchor_moving, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("no_result_yet", bus.out_valid, 1'b0);
    bus.nms_out   = all_ff;
    bus.nms_final = 1'b1;
    tick();
    bus.nms_final = 1'b0;
    bus.nms_out   = '0;
    chk("r1_valid", bus.out_valid, 1'b1);
    chk("r1_data", bus.out_data, all_ff);
    tick();
    chk("r1_held_valid", bus.out_valid, 1'b1);
    chk("r1_held_data", bus.out_data, all_ff);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("r1_cleared", bus.out_valid, 1'b0);

    // 12 further pixels mag=14..25 -> window overlaps the previous by two.
    for (int j = 0; j < 12; j++) send_pix(1'b0, 2'($urandom_range(0, 3)), 8'(14 + j));
    wait_anchor(4);
    chk("w2_elem0", bus.gradient_mag[7:0], 8'd12);
    chk("w2_elem1", bus.gradient_mag[15:8], 8'd13);
    chk("w2_elem13", bus.gradient_mag[111:104], 8'd25);
    d2 = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) tick();
    bus.nms_out   = d2;
    bus.nms_final = 1'b1;
    tick();
    bus.nms_final = 1'b0;
    chk("r2_valid", bus.out_valid, 1'b1);
    chk("r2_data", bus.out_data, d2);

    // Result unconsumed while staging fills: no new window until it drains.
    for (int j = 0; j < 12; j++) send_pix(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    a0 = anchor_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_no_issue", anchor_cnt, a0);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    chk("stall_data_stable", bus.out_data, d2);
    chk("stall_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    chk("drain_cleared", bus.out_valid, 1'b0);
    chk("drain_no_pulse_yet", bus.anchor_moving, 1'b0);
    tick();
    chk("drain_issue", bus.anchor_moving, 1'b1);
    anchor_pending = 1'b0;

    // nms_final during the issue cycle must be ignored; then no answer -> timeout.
    bus.nms_out   = {$urandom, $urandom, $urandom};
    bus.nms_final = 1'b1;
    tick();
    bus.nms_final = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    chk("to_not_yet", bus.err_timeout, 1'b0);
    tick();
    chk("to_err", bus.err_timeout, 1'b1);
    chk("to_no_valid", bus.out_valid, 1'b0);
    bus.nms_final = 1'b1;
    tick();
    bus.nms_final = 1'b0;
    tick();
    chk("stray_ignored", bus.out_valid, 1'b0);
    chk("err_sticky", bus.err_timeout, 1'b1);

    // Row restart after 7 pixels: window needs 13 more accepts after the new row start.
    send_pix(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    for (int j = 0; j < 6; j++) send_pix(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    a0 = anchor_cnt;
    send_pix(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    for (int j = 0; j < 12; j++) send_pix(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    tick();
    chk("sol_no_early_issue", anchor_cnt, a0);
    chk("sol_in_ready", bus.in_ready, 1'b1);
    send_pix(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    wait_anchor(4);

    // Reset in WAIT: outputs clear at once, a late nms_final is abandoned.
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("wait_rst");
    tick();
    rst = 1'b0;
    bus.nms_out   = all_ff;
    bus.nms_final = 1'b1;
    tick();
    bus.nms_final = 1'b0;
    tick();
    chk("post_rst_no_valid", bus.out_valid, 1'b0);
    chk("post_rst_no_anchor", bus.anchor_moving, 1'b0);
    chk("post_rst_err", bus.err_timeout, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
